// File: rtl/register_rename_pkg.sv
// Shared types and sizing constants for the register rename block.
//   PhysTag   : physical register tag
//   ArchAddr  : architectural register address
//   FreePtr   : free-list pointer, one bit wider than a tag so that
//               full and empty can be told apart
package register_rename_pkg;

    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int TAG_W     = $clog2(PHYS_REGS);
    localparam int ARCH_W    = $clog2(ARCH_REGS);
    // Physical registers left over after every architectural register
    // holds one mapping.
    localparam int FREE_REGS = PHYS_REGS - ARCH_REGS;

    typedef logic [TAG_W-1:0]  PhysTag;
    typedef logic [ARCH_W-1:0] ArchAddr;
    typedef logic [TAG_W:0]    FreePtr;

endpackage

// File: rtl/register_rename_if.sv
// Bundle of every rename-stage signal apart from clock and reset.
//   decode side : in_valid/in_ready, operand usage flags and addresses
//   queue side  : out_valid/out_ready, physical tags and source-ready bits
//   writeback   : wb_valid, wb_tag
//   commit      : commit_valid, commit_rw_addr, commit_rw_tag, commit_old_tag
//   recovery    : flush
//   status      : free_count
// modport slave is the rename stage; modport master is its environment.
interface register_rename_if;
    import register_rename_pkg::*;

    logic    in_valid;
    logic    in_ready;
    logic    in_uses_rs;
    logic    in_uses_rt;
    logic    in_uses_rw;
    ArchAddr in_rs_addr;
    ArchAddr in_rt_addr;
    ArchAddr in_rw_addr;

    logic    out_valid;
    logic    out_ready;
    PhysTag  out_rs_tag;
    PhysTag  out_rt_tag;
    PhysTag  out_rw_tag;
    PhysTag  out_old_rw_tag;
    logic    out_rs_ready;
    logic    out_rt_ready;

    logic    wb_valid;
    PhysTag  wb_tag;

    logic    commit_valid;
    ArchAddr commit_rw_addr;
    PhysTag  commit_rw_tag;
    PhysTag  commit_old_tag;

    logic    flush;
    FreePtr  free_count;

    modport slave (
        input  in_valid, in_uses_rs, in_uses_rt, in_uses_rw,
        input  in_rs_addr, in_rt_addr, in_rw_addr,
        output in_ready,
        output out_valid, out_rs_tag, out_rt_tag, out_rw_tag, out_old_rw_tag,
        output out_rs_ready, out_rt_ready,
        input  out_ready,
        input  wb_valid, wb_tag,
        input  commit_valid, commit_rw_addr, commit_rw_tag, commit_old_tag,
        input  flush,
        output free_count
    );

    modport master (
        output in_valid, in_uses_rs, in_uses_rt, in_uses_rw,
        output in_rs_addr, in_rt_addr, in_rw_addr,
        input  in_ready,
        input  out_valid, out_rs_tag, out_rt_tag, out_rw_tag, out_old_rw_tag,
        input  out_rs_ready, out_rt_ready,
        output out_ready,
        output wb_valid, wb_tag,
        output commit_valid, commit_rw_addr, commit_rw_tag, commit_old_tag,
        output flush,
        input  free_count
    );

endinterface

// File: rtl/register_rename_free_list.sv
// Circular FIFO of free physical tags.
//   clk, rst    : clock, asynchronous active-high reset
//   push_i      : append push_tag_i at the tail (tag released by commit)
//   pop_i       : consume the head entry (tag allocated by rename)
//   rewind_i    : move head back so exactly FREE_REGS entries are free
//   head_tag_o  : entry at the head, valid while count_o != 0
//   count_o     : number of free entries (tail - head)
module rename_free_list
    import register_rename_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  PhysTag push_tag_i,
    input  logic   pop_i,
    input  logic   rewind_i,
    output PhysTag head_tag_o,
    output FreePtr count_o
);

    PhysTag mem_q [PHYS_REGS];
    FreePtr head_q, head_d;
    FreePtr tail_q, tail_d;

    always_comb begin
        tail_d = tail_q + FreePtr'(push_i);
        // Rewind is relative to the post-push tail so that a commit in the
        // flush cycle is counted among the free registers. The rewound slots
        // still hold the tags that the squashed instructions had taken.
        if (rewind_i) begin
            head_d = tail_d - FreePtr'(FREE_REGS);
        end else begin
            head_d = head_q + FreePtr'(pop_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= FreePtr'(FREE_REGS);
            for (int i = 0; i < PHYS_REGS; i++) begin
                if (i < FREE_REGS) begin
                    mem_q[i] <= PhysTag'(i + ARCH_REGS);
                end else begin
                    mem_q[i] <= '0;
                end
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            if (push_i) begin
                mem_q[tail_q[TAG_W-1:0]] <= push_tag_i;
            end
        end
    end

    assign head_tag_o = mem_q[head_q[TAG_W-1:0]];
    assign count_o    = tail_q - head_q;

endmodule

// File: rtl/register_rename.sv
// Rename stage: maps architectural rs/rt/rw of each decoded instruction
// onto physical tags, tracks which physical registers are still pending
// (busy table), returns tags to the free list on commit and restores the
// speculative map from the retirement map on flush.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : register_rename_if.slave, decode input, queue output,
//              writeback, commit, flush and free_count
module register_rename
    import register_rename_pkg::*;
(
    input logic               clk,
    input logic               rst,
    register_rename_if.slave  bus
);

    PhysTag spec_map_q [ARCH_REGS];
    PhysTag spec_map_d [ARCH_REGS];
    PhysTag ret_map_q  [ARCH_REGS];
    PhysTag ret_map_d  [ARCH_REGS];
    logic [PHYS_REGS-1:0] busy_q, busy_d;

    logic   out_valid_q, out_valid_d;
    PhysTag rs_tag_q, rs_tag_d;
    PhysTag rt_tag_q, rt_tag_d;
    PhysTag rw_tag_q, rw_tag_d;
    PhysTag old_tag_q, old_tag_d;
    logic   rs_rdy_q, rs_rdy_d;
    logic   rt_rdy_q, rt_rdy_d;

    PhysTag head_tag;
    FreePtr free_count;
    logic   in_ready;
    logic   accept;
    logic   writes_rw;
    logic   alloc;
    PhysTag rs_tag_rd, rt_tag_rd;
    logic   rs_rdy_rd, rt_rdy_rd;

    // A source is ready if its producer already wrote back, or writes back
    // in this very cycle.
    function automatic logic src_ready(input PhysTag tag,
                                       input logic [PHYS_REGS-1:0] busy,
                                       input logic wb_v,
                                       input PhysTag wb_t);
        return ~busy[tag] | (wb_v & (wb_t == tag));
    endfunction

    assign in_ready  = ~bus.flush & (~out_valid_q | bus.out_ready) &
                       (free_count != '0);
    assign accept    = bus.in_valid & in_ready;
    // $0 is hard-wired: it never allocates and keeps tag 0.
    assign writes_rw = bus.in_uses_rw & (bus.in_rw_addr != '0);
    assign alloc     = accept & writes_rw;

    // Sources read the map as it stood before this instruction's own rw.
    assign rs_tag_rd = bus.in_uses_rs ? spec_map_q[bus.in_rs_addr] : '0;
    assign rt_tag_rd = bus.in_uses_rt ? spec_map_q[bus.in_rt_addr] : '0;
    assign rs_rdy_rd = bus.in_uses_rs ?
                       src_ready(rs_tag_rd, busy_q, bus.wb_valid, bus.wb_tag) : 1'b1;
    assign rt_rdy_rd = bus.in_uses_rt ?
                       src_ready(rt_tag_rd, busy_q, bus.wb_valid, bus.wb_tag) : 1'b1;

    rename_free_list u_free_list (
        .clk        (clk),
        .rst        (rst),
        .push_i     (bus.commit_valid),
        .push_tag_i (bus.commit_old_tag),
        .pop_i      (alloc),
        .rewind_i   (bus.flush),
        .head_tag_o (head_tag),
        .count_o    (free_count)
    );

    // Map tables and busy table.
    always_comb begin
        ret_map_d = ret_map_q;
        if (bus.commit_valid) begin
            ret_map_d[bus.commit_rw_addr] = bus.commit_rw_tag;
        end

        spec_map_d = spec_map_q;
        if (bus.flush) begin
            // Includes a commit landing in the same cycle as the flush.
            spec_map_d = ret_map_d;
        end else if (alloc) begin
            spec_map_d[bus.in_rw_addr] = head_tag;
        end

        busy_d = busy_q;
        if (bus.flush) begin
            busy_d = '0;
        end else begin
            if (bus.wb_valid) begin
                busy_d[bus.wb_tag] = 1'b0;
            end
            // Allocation wins over a same-cycle writeback to the same tag.
            if (alloc) begin
                busy_d[head_tag] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Output register toward the instruction queue.
    always_comb begin
        out_valid_d = out_valid_q;
        rs_tag_d    = rs_tag_q;
        rt_tag_d    = rt_tag_q;
        rw_tag_d    = rw_tag_q;
        old_tag_d   = old_tag_q;
        rs_rdy_d    = rs_rdy_q;
        rt_rdy_d    = rt_rdy_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            rs_tag_d    = rs_tag_rd;
            rt_tag_d    = rt_tag_rd;
            rs_rdy_d    = rs_rdy_rd;
            rt_rdy_d    = rt_rdy_rd;
            rw_tag_d    = writes_rw ? head_tag : '0;
            old_tag_d   = writes_rw ? spec_map_q[bus.in_rw_addr] : '0;
        end else begin
            if (bus.out_ready) begin
                out_valid_d = 1'b0;
            end
            // A held instruction keeps watching writeback; ready only rises.
            rs_rdy_d = rs_rdy_q | (bus.wb_valid & (bus.wb_tag == rs_tag_q));
            rt_rdy_d = rt_rdy_q | (bus.wb_valid & (bus.wb_tag == rt_tag_q));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                spec_map_q[i] <= PhysTag'(i);
                ret_map_q[i]  <= PhysTag'(i);
            end
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            rs_tag_q    <= '0;
            rt_tag_q    <= '0;
            rw_tag_q    <= '0;
            old_tag_q   <= '0;
            rs_rdy_q    <= 1'b0;
            rt_rdy_q    <= 1'b0;
        end else begin
            spec_map_q  <= spec_map_d;
            ret_map_q   <= ret_map_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            rs_tag_q    <= rs_tag_d;
            rt_tag_q    <= rt_tag_d;
            rw_tag_q    <= rw_tag_d;
            old_tag_q   <= old_tag_d;
            rs_rdy_q    <= rs_rdy_d;
            rt_rdy_q    <= rt_rdy_d;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_rs_tag     = rs_tag_q;
    assign bus.out_rt_tag     = rt_tag_q;
    assign bus.out_rw_tag     = rw_tag_q;
    assign bus.out_old_rw_tag = old_tag_q;
    assign bus.out_rs_ready   = rs_rdy_q;
    assign bus.out_rt_ready   = rt_rdy_q;
    assign bus.free_count     = free_count;

endmodule

// File: tb/tb_register_rename.sv
module tb_register_rename;
    import register_rename_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    register_rename_if bus ();

    register_rename dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       v;
        logic       urs, urt, urw;
        logic [4:0] rs, rt, rw;
        logic       wbv;
        logic [5:0] wbt;
        logic       cv;
        logic [4:0] ca;
        logic [5:0] ct, co;
        logic       fl;
        logic       ev;
        logic [5:0] ers;
        logic       ersr;
        logic [5:0] ert;
        logic       ertr;
        logic [5:0] erw, eold;
        logic [6:0] efc;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.in_valid       = 1'b0;
        bus.in_uses_rs     = 1'b0;
        bus.in_uses_rt     = 1'b0;
        bus.in_uses_rw     = 1'b0;
        bus.in_rs_addr     = '0;
        bus.in_rt_addr     = '0;
        bus.in_rw_addr     = '0;
        bus.out_ready      = 1'b1;
        bus.wb_valid       = 1'b0;
        bus.wb_tag         = '0;
        bus.commit_valid   = 1'b0;
        bus.commit_rw_addr = '0;
        bus.commit_rw_tag  = '0;
        bus.commit_old_tag = '0;
        bus.flush          = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic instr(input logic urs, input logic [4:0] rs,
                         input logic urw, input logic [4:0] rw);
        bus.in_valid   = 1'b1;
        bus.in_uses_rs = urs;
        bus.in_rs_addr = rs;
        bus.in_uses_rt = 1'b0;
        bus.in_rt_addr = '0;
        bus.in_uses_rw = urw;
        bus.in_rw_addr = rw;
    endtask

    initial begin
        //        v    urs  urt  urw  rs     rt     rw     wbv  wbt     cv   ca     ct      co      fl   ev   ers     ersr ert     ertr erw      eold   efc
        vt[0]  = '{1'b1,1'b1,1'b0,1'b1,5'd1, 5'd0, 5'd3, 1'b0,6'd0,  1'b0,5'd0, 6'd0,  6'd0,  1'b0,1'b1,6'd1,  1'b1,6'd0,  1'b1,6'd32, 6'd3, 7'd31};
        vt[1]  = '{1'b1,1'b1,1'b0,1'b0,5'd3, 5'd0, 5'd0, 1'b0,6'd0,  1'b0,5'd0, 6'd0,  6'd0,  1'b0,1'b1,6'd32, 1'b0,6'd0,  1'b1,6'd0,  6'd0, 7'd31};
        vt[2]  = '{1'b1,1'b1,1'b0,1'b0,5'd3, 5'd0, 5'd0, 1'b1,6'd32, 1'b0,5'd0, 6'd0,  6'd0,  1'b0,1'b1,6'd32, 1'b1,6'd0,  1'b1,6'd0,  6'd0, 7'd31};
        vt[3]  = '{1'b1,1'b0,1'b1,1'b0,5'd0, 5'd3, 5'd0, 1'b0,6'd0,  1'b0,5'd0, 6'd0,  6'd0,  1'b0,1'b1,6'd0,  1'b1,6'd32, 1'b1,6'd0,  6'd0, 7'd31};
        vt[4]  = '{1'b1,1'b1,1'b0,1'b1,5'd0, 5'd0, 5'd0, 1'b0,6'd0,  1'b0,5'd0, 6'd0,  6'd0,  1'b0,1'b1,6'd0,  1'b1,6'd0,  1'b1,6'd0,  6'd0, 7'd31};
        vt[5]  = '{1'b1,1'b1,1'b1,1'b1,5'd4, 5'd3, 5'd4, 1'b0,6'd0,  1'b0,5'd0, 6'd0,  6'd0,  1'b0,1'b1,6'd4,  1'b1,6'd32, 1'b1,6'd33, 6'd4, 7'd30};
        vt[6]  = '{1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,6'd0,  1'b0,5'd0, 6'd0,  6'd0,  1'b0,1'b0,6'd0,  1'b0,6'd0,  1'b0,6'd0,  6'd0, 7'd30};
        vt[7]  = '{1'b1,1'b0,1'b0,1'b1,5'd0, 5'd0, 5'd5, 1'b0,6'd0,  1'b1,5'd3, 6'd32, 6'd3,  1'b0,1'b1,6'd0,  1'b1,6'd0,  1'b1,6'd34, 6'd5, 7'd30};
        vt[8]  = '{1'b1,1'b0,1'b0,1'b1,5'd0, 5'd0, 5'd6, 1'b0,6'd0,  1'b0,5'd0, 6'd0,  6'd0,  1'b1,1'b0,6'd0,  1'b0,6'd0,  1'b0,6'd0,  6'd0, 7'd32};
        vt[9]  = '{1'b1,1'b1,1'b1,1'b1,5'd4, 5'd3, 5'd7, 1'b0,6'd0,  1'b0,5'd0, 6'd0,  6'd0,  1'b0,1'b1,6'd4,  1'b1,6'd32, 1'b1,6'd33, 6'd7, 7'd31};
        vt[10] = '{1'b1,1'b1,1'b0,1'b0,5'd5, 5'd0, 5'd0, 1'b0,6'd0,  1'b0,5'd0, 6'd0,  6'd0,  1'b0,1'b1,6'd5,  1'b1,6'd0,  1'b1,6'd0,  6'd0, 7'd31};

        // Reset state
        do_reset();
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_rs_tag", int'(bus.out_rs_tag), 0);
        chk("rst_rw_tag", int'(bus.out_rw_tag), 0);
        chk("rst_old_tag", int'(bus.out_old_rw_tag), 0);
        chk("rst_rs_ready", int'(bus.out_rs_ready), 0);
        chk("rst_rt_ready", int'(bus.out_rt_ready), 0);
        chk("rst_free_count", int'(bus.free_count), 32);
        chk("rst_in_ready", int'(bus.in_ready), 1);

        // Table-driven single-cycle vectors
        for (int i = 0; i < 11; i++) begin
            bus.in_valid       = vt[i].v;
            bus.in_uses_rs     = vt[i].urs;
            bus.in_uses_rt     = vt[i].urt;
            bus.in_uses_rw     = vt[i].urw;
            bus.in_rs_addr     = vt[i].rs;
            bus.in_rt_addr     = vt[i].rt;
            bus.in_rw_addr     = vt[i].rw;
            bus.wb_valid       = vt[i].wbv;
            bus.wb_tag         = vt[i].wbt;
            bus.commit_valid   = vt[i].cv;
            bus.commit_rw_addr = vt[i].ca;
            bus.commit_rw_tag  = vt[i].ct;
            bus.commit_old_tag = vt[i].co;
            bus.flush          = vt[i].fl;
            bus.out_ready      = 1'b1;
            step();
            idle();
            #1;
            chk($sformatf("v%0d_out_valid", i), int'(bus.out_valid), int'(vt[i].ev));
            chk($sformatf("v%0d_free_count", i), int'(bus.free_count), int'(vt[i].efc));
            if (vt[i].ev) begin
                chk($sformatf("v%0d_rs_tag", i), int'(bus.out_rs_tag), int'(vt[i].ers));
                chk($sformatf("v%0d_rs_ready", i), int'(bus.out_rs_ready), int'(vt[i].ersr));
                chk($sformatf("v%0d_rt_tag", i), int'(bus.out_rt_tag), int'(vt[i].ert));
                chk($sformatf("v%0d_rt_ready", i), int'(bus.out_rt_ready), int'(vt[i].ertr));
                chk($sformatf("v%0d_rw_tag", i), int'(bus.out_rw_tag), int'(vt[i].erw));
                chk($sformatf("v%0d_old_tag", i), int'(bus.out_old_rw_tag), int'(vt[i].eold));
            end
        end

        // Back-pressure: drain, then accept one instruction and hold it.
        idle();
        step();
        chk("bp_drain_valid", int'(bus.out_valid), 0);
        instr(1'b1, 5'd7, 1'b1, 5'd8);
        bus.out_ready = 1'b0;
        step();
        chk("bp_valid", int'(bus.out_valid), 1);
        chk("bp_rw_tag", int'(bus.out_rw_tag), 34);
        chk("bp_old_tag", int'(bus.out_old_rw_tag), 8);
        chk("bp_rs_tag", int'(bus.out_rs_tag), 33);
        chk("bp_rs_ready", int'(bus.out_rs_ready), 0);
        chk("bp_in_ready", int'(bus.in_ready), 0);
        for (int h = 0; h < 3; h++) begin
            instr(1'b1, 5'd1, 1'b1, 5'd9);
            bus.out_ready = 1'b0;
            bus.wb_valid  = (h == 1);
            bus.wb_tag    = 6'd33;
            step();
            bus.wb_valid = 1'b0;
            chk($sformatf("hold%0d_valid", h), int'(bus.out_valid), 1);
            chk($sformatf("hold%0d_rw_tag", h), int'(bus.out_rw_tag), 34);
            chk($sformatf("hold%0d_rs_tag", h), int'(bus.out_rs_tag), 33);
            chk($sformatf("hold%0d_rs_ready", h), int'(bus.out_rs_ready), (h >= 1) ? 1 : 0);
            chk($sformatf("hold%0d_free_count", h), int'(bus.free_count), 30);
            chk($sformatf("hold%0d_in_ready", h), int'(bus.in_ready), 0);
        end
        idle();
        step();
        chk("bp_release_valid", int'(bus.out_valid), 0);
        chk("bp_release_free_count", int'(bus.free_count), 30);

        // Free-list exhaustion and refill from a commit.
        do_reset();
        for (int k = 0; k < 32; k++) begin
            instr(1'b0, 5'd0, 1'b1, 5'((k % 31) + 1));
            #1;
            chk($sformatf("exh%0d_in_ready", k), int'(bus.in_ready), 1);
            step();
        end
        idle();
        #1;
        chk("exh_last_rw_tag", int'(bus.out_rw_tag), 63);
        chk("exh_free_count", int'(bus.free_count), 0);
        chk("exh_in_ready", int'(bus.in_ready), 0);
        instr(1'b0, 5'd0, 1'b1, 5'd2);
        bus.commit_valid   = 1'b1;
        bus.commit_rw_addr = 5'd1;
        bus.commit_rw_tag  = 6'd32;
        bus.commit_old_tag = 6'd5;
        step();
        idle();
        #1;
        chk("exh_reject_valid", int'(bus.out_valid), 0);
        chk("exh_commit_free_count", int'(bus.free_count), 1);
        chk("exh_commit_in_ready", int'(bus.in_ready), 1);
        instr(1'b0, 5'd0, 1'b1, 5'd2);
        step();
        idle();
        #1;
        chk("exh_realloc_valid", int'(bus.out_valid), 1);
        chk("exh_realloc_rw_tag", int'(bus.out_rw_tag), 5);
        chk("exh_realloc_old_tag", int'(bus.out_old_rw_tag), 33);
        chk("exh_realloc_free_count", int'(bus.free_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
